pan_stream_tx: RTL

Transmit-side counterpart of the PAN digit-stream interface. It takes a stored nibble-packed PAN and its length through a valid/ready load handshake, then replays it as the per-digit stream: a start pulse, then digits with digit_valid, with pan_end on the last digit. It is used as the card source for loopback and system tests of the validator front end, and as the replay path from the PAN buffer.

---
 rtl/pan_pkg.sv | 23 ++
 rtl/pan_luhn_acc.sv | 30 +++
 rtl/pan_stream_tx.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pan_pkg.sv
// Shared types and helpers for the PAN digit-stream blocks.
package pan_pkg;

    localparam int PAN_W       = 76;
    localparam int LEN_W       = 5;
    localparam int PAN_NIBBLES = 19;

    typedef enum logic [2:0] {
        IDLE,
        START,
        GAP,
        DIGIT,
        END
    } tx_state_e;

    // Luhn doubling: 2*d, folded back into one digit by subtracting 9.
    function automatic logic [3:0] luhn_dbl(input logic [3:0] d);
        logic [4:0] t;
        t = {d, 1'b0};
        return (t > 5'd9) ? 4'(t - 5'd9) : t[3:0];
    endfunction

endpackage

// File: rtl/pan_luhn_acc.sv
// Running Luhn sum (mod 10) over emitted digits; presents the matching check digit.
module pan_luhn_acc
    import pan_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       en,
    input  logic [3:0] digit,
    input  logic       dbl_sel,
    output logic [3:0] check_digit
);

    logic [3:0] sum;
    logic [3:0] term;
    logic [4:0] s5;

    assign term = dbl_sel ? luhn_dbl(digit) : digit;
    assign s5   = {1'b0, sum} + {1'b0, term};

    always_ff @(posedge clk) begin
        if (!rst_n || clear)
            sum <= 4'd0;
        else if (en)
            sum <= (s5 >= 5'd10) ? 4'(s5 - 5'd10) : s5[3:0];
    end

    assign check_digit = (sum == 4'd0) ? 4'd0 : 4'd10 - sum;

endmodule

// File: rtl/pan_stream_tx.sv
// Replays a loaded nibble-packed PAN as a start pulse followed by a per-digit stream.
// Optional: define PAN_TX_LUHN_GEN_EN to replace the last digit with a generated Luhn check digit.
module pan_stream_tx #(
    parameter int MAX_LEN     = 16,
    parameter int GAP_CYCLES  = 0,
    parameter int PAN_NIBBLES = 19
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [4*PAN_NIBBLES-1:0] pan_in,
    input  logic [4:0]               len_in,
    input  logic                     pause,
    output logic                     start,
    output logic                     digit_valid,
    output logic [3:0]               digit_out,
    output logic                     pan_end,
    output logic                     busy,
    output logic                     tx_done,
    output logic                     len_err
);
    import pan_pkg::*;

    localparam logic [4:0] MAX_L    = 5'(MAX_LEN);
    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    localparam bit         HAS_GAP  = (GAP_CYCLES > 0);

    tx_state_e state, state_nx;

    logic [4*PAN_NIBBLES-1:0] pan_q;
    logic [4:0]               len_q;
    logic [4:0]               idx;
    logic [3:0]               gap_cnt;
    logic                     pause_q;
    logic                     len_err_q;
    logic                     last;
    logic                     send;
    logic [3:0]               nib;

    // pause is registered so every output stays a pure function of flops.
    assign last = (idx == len_q - 5'd1);
    assign send = (state == DIGIT) && !pause_q;
    assign nib  = pan_q[{idx, 2'b00} +: 4];

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = START;
            START:   if (len_q == 5'd0) state_nx = END;
                     else if (HAS_GAP)  state_nx = GAP;
                     else               state_nx = DIGIT;
            GAP:     if (gap_cnt == 4'd0) state_nx = DIGIT;
            DIGIT:   if (send) begin
                         if (last)         state_nx = IDLE;
                         else if (HAS_GAP) state_nx = GAP;
                     end
            END:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pan_q     <= '0;
            len_q     <= 5'd0;
            idx       <= 5'd0;
            gap_cnt   <= 4'd0;
            pause_q   <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state     <= state_nx;
            pause_q   <= pause;
            len_err_q <= 1'b0;
            if (state == IDLE && req_valid) begin
                pan_q     <= pan_in;
                len_q     <= (len_in > MAX_L) ? MAX_L : len_in;
                len_err_q <= (len_in > MAX_L);
                idx       <= 5'd0;
            end
            if (state_nx == GAP && state != GAP)
                gap_cnt <= GAP_LOAD;
            else if (state == GAP)
                gap_cnt <= gap_cnt - 4'd1;
            if (send && !last)
                idx <= idx + 5'd1;
        end
    end

    assign req_ready   = (state == IDLE);
    assign busy        = (state != IDLE);
    assign start       = (state == START);
    assign digit_valid = send;
    assign pan_end     = (send && last) || (state == END);
    assign tx_done     = (send && last) || (state == END);
    assign len_err     = len_err_q;

`ifdef PAN_TX_LUHN_GEN_EN
    logic [3:0] check_digit;
    logic [4:0] rem;

    // Digits whose distance to the check position is odd get doubled.
    assign rem = len_q - 5'd1 - idx;

    pan_luhn_acc u_luhn (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (state == IDLE),
        .en          (send && !last),
        .digit       (nib),
        .dbl_sel     (rem[0]),
        .check_digit (check_digit)
    );

    assign digit_out = !send ? 4'd0 : (last ? check_digit : nib);
`else
    assign digit_out = send ? nib : 4'd0;
`endif

endmodule
